// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end.
// Contents: IF slot state encoding, IF->ID bus width, reset PC default and
// the SRAM transfer size code for a 32-bit word.
// Optional feature macro: IF_ADEF_EN. It widens the IF->ID bus by one bit,
// which carries the fetch address-error flag.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_WAIT  = 2'd1,
    SLOT_HOLD  = 2'd2
  } slot_e;

`ifdef IF_ADEF_EN
  localparam int IF_TO_ID_BUS_W = 65;
`else
  localparam int IF_TO_ID_BUS_W = 64;
`endif

  localparam logic [31:0] RESET_PC_DEF   = 32'h1c000000;
  localparam logic [1:0]  INST_SIZE_WORD = 2'b10;

endpackage

// File: rtl/if_fetch_unit_if.sv
// SRAM-like instruction port (req/addr_ok/data_ok handshake).
// master: the fetch unit. It drives req, wr, size, wstrb, addr and wdata, and
//         receives addr_ok, data_ok and rdata.
// slave : the instruction memory side.
interface if_fetch_unit_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, wstrb, addr, wdata,
                  input  addr_ok, data_ok, rdata);
  modport slave  (input  req, wr, size, wstrb, addr, wdata,
                  output addr_ok, data_ok, rdata);
endinterface

// File: rtl/if_fetch_unit_inst_buffer.sv
// One-entry instruction holding register with a bypass path.
// Ports:
//   clk        clock
//   i_capture  load i_rdata into the holding register
//   i_hold_sel 1: output the held word, 0: pass i_rdata straight through
//   i_rdata    incoming instruction word
//   o_inst     instruction presented to ID
module if_inst_buffer (
  input  logic        clk,
  input  logic        i_capture,
  input  logic        i_hold_sel,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_inst
);

  logic [31:0] r_inst;

  always_ff @(posedge clk) begin
    if (i_capture) r_inst <= i_rdata;
  end

  assign o_inst = i_hold_sel ? r_inst : i_rdata;

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch front end (pre-IF PC generation plus the IF slot).
// It issues word fetches on the SRAM-like instruction port, keeps at most one
// response outstanding, buffers one instruction while ID stalls, and hands
// {pc, inst} to ID.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   wb_ex / wb_target         flush redirect from WB (wins over a branch)
//   id_br_taken/id_br_target  branch redirect from ID
//   id_allow_in               ID can accept this cycle
//   id_need_cancel            nonzero: instruction leaving IF is stale
//   inst_sram                 instruction port (master modport)
//   if_ready_go               IF holds a valid instruction
//   pipeline_is_not_stalled   if_ready_go & id_allow_in
//   if_to_id_valid/_bus       {[adef,] pc, inst} to ID
// Optional feature macro: IF_ADEF_EN. A misaligned PC issues no fetch. It goes
// straight to HOLD with inst = 0 and the adef flag set in bit 64 of the bus.
module if_fetch_unit import if_fetch_unit_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_ex,
  input  logic [31:0]               wb_target,
  input  logic                      id_br_taken,
  input  logic [31:0]               id_br_target,
  input  logic                      id_allow_in,
  input  logic [1:0]                id_need_cancel,
  if_fetch_unit_if.master           inst_sram,
  output logic                      if_ready_go,
  output logic                      pipeline_is_not_stalled,
  output logic                      if_to_id_valid,
  output logic [IF_TO_ID_BUS_W-1:0] if_to_id_bus
);

  slot_e       r_slot, w_slot_nxt;
  logic        r_pre_valid;
  logic [31:0] r_pc, r_slot_pc, r_redir_pc;
  logic        r_redir_vld, r_redir_ex;
  logic        w_adef, w_ready_go, w_handoff, w_can_accept, w_req;
  logic        w_accept, w_adef_take, w_take, w_capture;
  logic        w_br_eff, w_redir;
  logic [31:0] w_redir_tgt, w_pc_nxt, w_inst, w_buf_din;
  logic [IF_TO_ID_BUS_W-1:0] w_bus;

`ifdef IF_ADEF_EN
  logic r_slot_adef;
  assign w_adef = |r_pc[1:0];
`else
  assign w_adef = 1'b0;
`endif

  assign w_ready_go   = ((r_slot == SLOT_WAIT) & inst_sram.data_ok) | (r_slot == SLOT_HOLD);
  assign w_handoff    = w_ready_go & id_allow_in;
  // The slot can take a new PC when empty, or when its occupant leaves this cycle.
  assign w_can_accept = (r_slot == SLOT_EMPTY) | w_handoff;
  assign w_req        = r_pre_valid & w_can_accept & ~w_adef;
  assign w_accept     = w_req & inst_sram.addr_ok;
  assign w_adef_take  = r_pre_valid & w_can_accept & w_adef;
  assign w_take       = w_accept | w_adef_take;

  // A branch from ID cannot displace a flush target that is already parked.
  assign w_br_eff    = id_br_taken & ~(r_redir_vld & r_redir_ex);
  assign w_redir     = wb_ex | w_br_eff;
  assign w_redir_tgt = wb_ex ? wb_target : id_br_target;

  always_comb begin
    if (w_redir)          w_pc_nxt = w_redir_tgt;
    else if (r_redir_vld) w_pc_nxt = r_redir_pc;
    else                  w_pc_nxt = r_pc + 32'd4;
  end

  // pre-IF: PC and redirect latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_valid <= 1'b0;
      r_pc        <= RESET_PC;
      r_redir_vld <= 1'b0;
      r_redir_ex  <= 1'b0;
    end else begin
      r_pre_valid <= 1'b1;
      if (w_take) begin
        r_pc        <= w_pc_nxt;
        r_redir_vld <= 1'b0;
        r_redir_ex  <= 1'b0;
      end else if (w_req) begin
        // Address phase is stalled: addr must not move, so park the redirect.
        if (w_redir) begin
          r_redir_vld <= 1'b1;
          r_redir_ex  <= wb_ex;
        end
      end else if (w_redir) begin
        r_pc        <= w_redir_tgt;
        r_redir_vld <= 1'b0;
        r_redir_ex  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_req & ~inst_sram.addr_ok & w_redir) r_redir_pc <= w_redir_tgt;
  end

  // IF slot: state register
  always_ff @(posedge clk) begin
    if (rst) r_slot <= SLOT_EMPTY;
    else     r_slot <= w_slot_nxt;
  end

  // IF slot: next state
  always_comb begin
    w_slot_nxt = r_slot;
    if (w_accept)         w_slot_nxt = SLOT_WAIT;
    else if (w_adef_take) w_slot_nxt = SLOT_HOLD;
    else begin
      case (r_slot)
        SLOT_WAIT: if (inst_sram.data_ok) w_slot_nxt = id_allow_in ? SLOT_EMPTY : SLOT_HOLD;
        SLOT_HOLD: if (id_allow_in)       w_slot_nxt = SLOT_EMPTY;
        default:                          w_slot_nxt = SLOT_EMPTY;
      endcase
    end
  end

  // IF slot: outputs
  always_comb begin
    if_ready_go             = w_ready_go;
    pipeline_is_not_stalled = w_handoff;
    if_to_id_valid          = w_ready_go & (id_need_cancel == 2'b00) & ~wb_ex;
    w_capture               = ((r_slot == SLOT_WAIT) & inst_sram.data_ok & ~id_allow_in)
                              | w_adef_take;
  end

  always_ff @(posedge clk) begin
    if (w_take) r_slot_pc <= r_pc;
  end

`ifdef IF_ADEF_EN
  always_ff @(posedge clk) begin
    if (w_take) r_slot_adef <= w_adef_take;
  end
  assign w_bus = {r_slot_adef, r_slot_pc, w_inst};
`else
  assign w_bus = {r_slot_pc, w_inst};
`endif

  assign w_buf_din = w_adef_take ? 32'h0 : inst_sram.rdata;

  if_inst_buffer u_buf (
    .clk       (clk),
    .i_capture (w_capture),
    .i_hold_sel(r_slot == SLOT_HOLD),
    .i_rdata   (w_buf_din),
    .o_inst    (w_inst)
  );

  assign if_to_id_bus = w_ready_go ? w_bus : '0;

  assign inst_sram.req   = w_req;
  assign inst_sram.wr    = 1'b0;
  assign inst_sram.size  = INST_SIZE_WORD;
  assign inst_sram.wstrb = 4'h0;
  assign inst_sram.addr  = r_pc;
  assign inst_sram.wdata = 32'h0;

`ifndef SYNTHESIS
  // A response that was outstanding across a reset may still arrive once; it
  // is dropped silently. Any other data_ok with no request in flight is an error.
  logic r_stray_ok;
  always_ff @(posedge clk) begin
    if (rst)                    r_stray_ok <= r_stray_ok | (r_slot == SLOT_WAIT);
    else if (inst_sram.data_ok) r_stray_ok <= 1'b0;
  end

  a_no_orphan_data: assert property (@(posedge clk) disable iff (rst)
    !(inst_sram.data_ok && (r_slot == SLOT_EMPTY) && !r_stray_ok));
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: per-cycle vector table plus delivery scoreboard.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam logic [31:0] RPC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_ex = 1'b0;
  logic [31:0] wb_target = 32'h0;
  logic        id_br_taken = 1'b0;
  logic [31:0] id_br_target = 32'h0;
  logic        id_allow_in = 1'b0;
  logic [1:0]  id_need_cancel = 2'b00;
  logic        if_ready_go, pipeline_is_not_stalled, if_to_id_valid;
  logic [IF_TO_ID_BUS_W-1:0] if_to_id_bus;

  if_fetch_unit_if inst_sram();

  if_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .wb_ex                  (wb_ex),
    .wb_target              (wb_target),
    .id_br_taken            (id_br_taken),
    .id_br_target           (id_br_target),
    .id_allow_in            (id_allow_in),
    .id_need_cancel         (id_need_cancel),
    .inst_sram              (inst_sram),
    .if_ready_go            (if_ready_go),
    .pipeline_is_not_stalled(pipeline_is_not_stalled),
    .if_to_id_valid         (if_to_id_valid),
    .if_to_id_bus           (if_to_id_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rs, aok, dok, allow, br, ex;
    logic [1:0]  cn;
    logic [31:0] rd, brt, ext, ppc;
    logic        e_req, e_rdy, e_vld;
    logic [31:0] e_addr;
  } row_t;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb[$];

  function automatic row_t mk(input int rs, aok, dok, al, br, ex, cn,
                              input logic [31:0] rd, brt, ext, ppc,
                              input int er, input logic [31:0] ea, input int erdy, evld);
    row_t r;
    r.rs = rs[0]; r.aok = aok[0]; r.dok = dok[0]; r.allow = al[0];
    r.br = br[0]; r.ex = ex[0]; r.cn = cn[1:0];
    r.rd = rd; r.brt = brt; r.ext = ext; r.ppc = ppc;
    r.e_req = er[0]; r.e_addr = ea; r.e_rdy = erdy[0]; r.e_vld = evld[0];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input row_t r, input int idx);
    logic [63:0] e;
    @(posedge clk);
    #1;
    rst = r.rs; inst_sram.addr_ok = r.aok; inst_sram.data_ok = r.dok;
    inst_sram.rdata = r.rd; id_allow_in = r.allow; id_br_taken = r.br;
    id_br_target = r.brt; wb_ex = r.ex; wb_target = r.ext; id_need_cancel = r.cn;
    if (r.ppc != 32'h0) sb.push_back({r.ppc, r.rd});
    #1;
    chk($sformatf("req[%0d]", idx),  64'(inst_sram.req),  64'(r.e_req));
    chk($sformatf("addr[%0d]", idx), 64'(inst_sram.addr), 64'(r.e_addr));
    chk($sformatf("rdy[%0d]", idx),  64'(if_ready_go),    64'(r.e_rdy));
    chk($sformatf("vld[%0d]", idx),  64'(if_to_id_valid), 64'(r.e_vld));
    chk($sformatf("pns[%0d]", idx),  64'(pipeline_is_not_stalled), 64'(r.e_rdy & r.allow));
    if (if_to_id_valid && id_allow_in) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL deliver[%0d]: got %h expected nothing", idx, if_to_id_bus[63:0]);
      end else begin
        e = sb.pop_front();
        chk($sformatf("bus[%0d]", idx), if_to_id_bus[63:0], e);
      end
    end
  endtask

  initial begin
    row_t rows[$];
    // rs aok dok al br ex cn | rdata brt ext | push_pc | req addr rdy vld
    rows.push_back(mk(0,1,0,1,0,0,0, 0,0,0, 0,                         1,32'h1c000000,0,0));
    rows.push_back(mk(0,1,1,1,0,0,0, 32'h11111111,0,0, 32'h1c000000,   1,32'h1c000004,1,1));
    rows.push_back(mk(0,1,1,1,0,0,0, 32'h22222222,0,0, 32'h1c000004,   1,32'h1c000008,1,1));
    rows.push_back(mk(0,1,1,0,0,0,0, 32'h02c00421,0,0, 32'h1c000008,   0,32'h1c00000c,1,1));
    rows.push_back(mk(0,1,0,0,0,0,0, 0,0,0, 0,                         0,32'h1c00000c,1,1));
    rows.push_back(mk(0,1,0,0,0,0,0, 0,0,0, 0,                         0,32'h1c00000c,1,1));
    rows.push_back(mk(0,1,0,1,0,0,0, 0,0,0, 0,                         1,32'h1c00000c,1,1));
    rows.push_back(mk(0,0,1,1,0,0,0, 32'h33333333,0,0, 32'h1c00000c,   1,32'h1c000010,1,1));
    rows.push_back(mk(0,0,0,1,1,0,0, 0,32'h1c000100,0, 0,              1,32'h1c000010,0,0));
    rows.push_back(mk(0,0,0,1,0,0,0, 0,0,0, 0,                         1,32'h1c000010,0,0));
    rows.push_back(mk(0,0,0,1,0,0,0, 0,0,0, 0,                         1,32'h1c000010,0,0));
    rows.push_back(mk(0,1,0,1,0,0,0, 0,0,0, 0,                         1,32'h1c000010,0,0));
    rows.push_back(mk(0,1,1,1,0,0,1, 32'h44444444,0,0, 0,              1,32'h1c000100,1,0));
    rows.push_back(mk(0,1,1,1,0,0,0, 32'h55555555,0,0, 32'h1c000100,   1,32'h1c000104,1,1));
    rows.push_back(mk(0,0,0,1,1,1,0, 0,32'h1c000200,32'h1c008000, 0,   0,32'h1c000108,0,0));
    rows.push_back(mk(0,1,1,1,0,0,1, 32'h66666666,0,0, 0,              1,32'h1c008000,1,0));
    rows.push_back(mk(0,0,1,1,0,0,0, 32'h77777777,0,0, 32'h1c008000,   1,32'h1c008004,1,1));
    rows.push_back(mk(0,1,0,1,0,0,0, 0,0,0, 0,                         1,32'h1c008004,0,0));
    rows.push_back(mk(1,0,0,1,0,0,0, 0,0,0, 0,                         0,32'h1c008008,0,0));
    rows.push_back(mk(0,0,1,1,0,0,0, 32'h88888888,0,0, 0,              0,32'h1c000000,0,0));
    rows.push_back(mk(0,0,0,1,0,0,0, 0,0,0, 0,                         1,32'h1c000000,0,0));
    rows.push_back(mk(0,1,0,1,0,0,0, 0,0,0, 0,                         1,32'h1c000000,0,0));
    rows.push_back(mk(0,0,1,1,0,0,0, 32'h99999999,0,0, 32'h1c000000,   1,32'h1c000004,1,1));

    inst_sram.addr_ok = 1'b0;
    inst_sram.data_ok = 1'b0;
    inst_sram.rdata   = 32'h0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_req",   64'(inst_sram.req),   64'(0));
    chk("rst_addr",  64'(inst_sram.addr),  64'(RPC));
    chk("rst_size",  64'(inst_sram.size),  64'(2'b10));
    chk("rst_wr",    64'(inst_sram.wr),    64'(0));
    chk("rst_wstrb", 64'(inst_sram.wstrb), 64'(0));
    chk("rst_wdata", 64'(inst_sram.wdata), 64'(0));
    chk("rst_rdy",   64'(if_ready_go),     64'(0));
    chk("rst_vld",   64'(if_to_id_valid),  64'(0));
    chk("rst_pns",   64'(pipeline_is_not_stalled), 64'(0));
    chk("rst_bus",   if_to_id_bus[63:0],   64'(0));

    for (int i = 0; i < rows.size(); i++) apply(rows[i], i + 1);

`ifdef IF_ADEF_EN
    apply(mk(0,0,0,1,1,0,0, 0,32'h1c000102,0, 0, 1,32'h1c000004,0,0), 101);
    apply(mk(0,1,0,1,0,0,0, 0,0,0, 0,             1,32'h1c000004,0,0), 102);
    apply(mk(0,0,1,1,0,0,1, 32'hdeadbeef,0,0, 0,  0,32'h1c000102,1,0), 103);
    apply(mk(0,0,0,0,0,0,0, 0,0,0, 0,             0,32'h1c000106,1,1), 104);
    chk("adef_flag", 64'(if_to_id_bus[64]),    64'(1));
    chk("adef_pc",   64'(if_to_id_bus[63:32]), 64'(32'h1c000102));
    chk("adef_inst", 64'(if_to_id_bus[31:0]),  64'(0));
`endif

    chk("sb_drain", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
